// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and the strip readers:
// FSM encoding, saturation limits and the 8-bit saturation helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO,
        ACK
    } arb_state_t;

    localparam int signed SAT_MIN = 0;
    localparam int signed SAT_MAX = 255;

    // Callers sign-extend their result to 64 bits before calling.
    function automatic logic [7:0] sat8(input logic signed [63:0] value);
        if (value < 64'(SAT_MIN)) begin
            return 8'(SAT_MIN);
        end else if (value > 64'(SAT_MAX)) begin
            return 8'(SAT_MAX);
        end else begin
            return value[7:0];
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational round-robin picker: first set request after rr_ptr,
// wrapping modulo NUM_REQ, returned one-hot and as an index.
module rr_priority_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART TX: per grant, serve up to BURST_LEN
// saturated bytes through the tx_send/tx_busy handshake and ack each one.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 8,
    parameter int DATA_W    = 23,
    parameter int BURST_LEN = 1,
    parameter int BUSY_WAIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      tx_busy,
    output logic                      tx_send,
    output logic [7:0]                tx_data,
    output logic                      active,
    output logic [31:0]               bytes_sent
);

    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
    localparam logic [7:0] WAIT_LAST = 8'(BUSY_WAIT - 1);

    arb_state_t               state, state_next;
    logic [IDX_W-1:0]         rr_ptr, owner_idx, win_idx;
    logic [NUM_REQ-1:0]       winner;
    logic                     found;
    logic [7:0]               burst_cnt, wait_cnt;
    logic signed [DATA_W-1:0] slot, data_q;

    rr_priority_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .win_idx(win_idx),
        .found  (found)
    );

    assign slot   = req_data[owner_idx*DATA_W +: DATA_W];
    assign active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (!tx_busy) state_next = WAIT_HI;
            // A UART that never raises busy must not stall the arbiter.
            WAIT_HI: if (tx_busy || wait_cnt == WAIT_LAST) state_next = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_next = ACK;
            ACK: begin
                if (req[owner_idx] && burst_cnt < BURST_MAX) begin
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            ack        <= '0;
            tx_send    <= 1'b0;
            tx_data    <= '0;
            bytes_sent <= '0;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            owner_idx  <= '0;
            burst_cnt  <= '0;
            wait_cnt   <= '0;
        end else begin
            ack     <= '0;
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= winner;
                        owner_idx <= win_idx;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= sat8(64'(data_q));
                        tx_send  <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                WAIT_HI: wait_cnt <= wait_cnt + 8'd1;
                // ack and the counters update together so ack coincides with the new count.
                WAIT_LO: begin
                    if (!tx_busy) begin
                        ack        <= grant;
                        bytes_sent <= bytes_sent + 32'd1;
                        burst_cnt  <= burst_cnt + 8'd1;
                    end
                end
                ACK: begin
                    if (state_next == IDLE) begin
                        rr_ptr    <= owner_idx;
                        grant     <= '0;
                        burst_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data register carries no reset; it is only observed after a LOAD.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            data_q <= slot;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with single-byte grants,
// one with 4-byte bursts, each driven by a simple busy-window UART model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 8;
    localparam int DATA_W  = 23;
    localparam int FRAME_A = 10;
    localparam int FRAME_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance A: BURST_LEN=1
    logic [NUM_REQ-1:0]        req_a = '0;
    logic signed [DATA_W-1:0]  slot_a [NUM_REQ];
    logic [NUM_REQ*DATA_W-1:0] req_data_a;
    logic [NUM_REQ-1:0]        grant_a, ack_a;
    logic                      tx_busy_a, tx_send_a, active_a;
    logic [7:0]                tx_data_a;
    logic [31:0]               bytes_sent_a;
    int                        uart_cnt_a = 0;
    logic                      uart_en_a = 1'b1;

    // instance B: BURST_LEN=4
    logic [NUM_REQ-1:0]        req_b = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data_b;
    logic [NUM_REQ-1:0]        grant_b, ack_b;
    logic                      tx_busy_b, tx_send_b, active_b;
    logic [7:0]                tx_data_b;
    logic [31:0]               bytes_sent_b;
    int                        uart_cnt_b = 0;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_data_a[g*DATA_W +: DATA_W] = slot_a[g];
        assign req_data_b[g*DATA_W +: DATA_W] = DATA_W'(g + 1);
    end

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_LEN(1), .BUSY_WAIT(4)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_data(req_data_a),
        .grant(grant_a), .ack(ack_a), .tx_busy(tx_busy_a), .tx_send(tx_send_a),
        .tx_data(tx_data_a), .active(active_a), .bytes_sent(bytes_sent_a)
    );

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_LEN(4), .BUSY_WAIT(4)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_data(req_data_b),
        .grant(grant_b), .ack(ack_b), .tx_busy(tx_busy_b), .tx_send(tx_send_b),
        .tx_data(tx_data_b), .active(active_b), .bytes_sent(bytes_sent_b)
    );

    // UART model: busy for FRAME cycles starting the cycle after tx_send
    always @(posedge clk) begin
        if (tx_send_a && uart_en_a) uart_cnt_a <= FRAME_A;
        else if (uart_cnt_a != 0)   uart_cnt_a <= uart_cnt_a - 1;
        if (tx_send_b)              uart_cnt_b <= FRAME_B;
        else if (uart_cnt_b != 0)   uart_cnt_b <= uart_cnt_b - 1;
    end
    assign tx_busy_a = (uart_cnt_a != 0);
    assign tx_busy_b = (uart_cnt_b != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send_a(input string tag);
        int n = 0;
        while (!tx_send_a && n < 60) begin tick(); n++; end
        check({tag, "_send"}, 32'(tx_send_a), 32'd1);
    endtask

    task automatic wait_ack_a(input string tag);
        int n = 0;
        while (ack_a == '0 && n < 60) begin tick(); n++; end
        check({tag, "_ackseen"}, 32'(ack_a != '0), 32'd1);
    endtask

    task automatic serve_a(input int idx, input logic signed [DATA_W-1:0] d,
                           input logic [7:0] exp_byte, input string tag);
        slot_a[idx] = d;
        req_a[idx]  = 1'b1;
        wait_send_a(tag);
        check({tag, "_grant"}, 32'(grant_a), 32'(1 << idx));
        check({tag, "_byte"}, 32'(tx_data_a), 32'(exp_byte));
        wait_ack_a(tag);
        check({tag, "_ack"}, 32'(ack_a), 32'(1 << idx));
        req_a[idx] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_idx;
        int t0;
        int acks;
        int burst_order [10] = '{3, 3, 3, 3, 5, 5, 5, 5, 3, 3};

        for (int i = 0; i < NUM_REQ; i++) slot_a[i] = '0;

        // reset values
        tick(); tick();
        check("rst_grant", 32'(grant_a), 32'd0);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_send", 32'(tx_send_a), 32'd0);
        check("rst_data", 32'(tx_data_a), 32'd0);
        check("rst_bytes", bytes_sent_a, 32'd0);
        check("rst_active", 32'(active_a), 32'd0);

        // single requester, data 100: grant +1, tx_send +3
        reset     = 1'b0;
        slot_a[0] = DATA_W'(100);
        req_a[0]  = 1'b1;
        tick();
        check("s1_grant", 32'(grant_a), 32'd1);
        check("s1_active", 32'(active_a), 32'd1);
        tick(); tick();
        check("s1_send", 32'(tx_send_a), 32'd1);
        check("s1_byte", 32'(tx_data_a), 32'h64);
        tick();
        check("s1_pulse", 32'(tx_send_a), 32'd0);
        wait_ack_a("s1");
        check("s1_ack", 32'(ack_a), 32'd1);
        check("s1_bytes", bytes_sent_a, 32'd1);
        check("s1_hold", 32'(tx_data_a), 32'h64);
        req_a[0] = 1'b0;
        tick();
        check("s1_ackoff", 32'(ack_a), 32'd0);
        check("s1_idle", 32'(active_a), 32'd0);
        check("s1_gntoff", 32'(grant_a), 32'd0);

        // saturation on requester 2
        serve_a(2, DATA_W'(-5), 8'h00, "sat_neg");
        serve_a(2, DATA_W'(300), 8'hFF, "sat_hi");
        serve_a(2, DATA_W'(255), 8'hFF, "sat_255");
        check("sat_bytes", bytes_sent_a, 32'd4);

        // UART never raises busy: ack 5 cycles after tx_send
        uart_en_a = 1'b0;
        slot_a[4] = DATA_W'(7);
        req_a[4]  = 1'b1;
        wait_send_a("nobusy");
        t0 = 0;
        while (ack_a == '0 && t0 < 30) begin tick(); t0++; end
        check("nobusy_lat", 32'(t0), 32'd5);
        check("nobusy_ack", 32'(ack_a), 32'h10);
        req_a[4] = 1'b0;
        tick();
        check("nobusy_idle", 32'(active_a), 32'd0);
        uart_en_a = 1'b1;

        // round robin, all requesting, 16 bytes
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) slot_a[i] = DATA_W'(10 * i);
        req_a   = 8'hFF;
        exp_idx = 0;
        acks    = 0;
        for (int k = 0; k < 16; k++) begin
            wait_ack_a("rr");
            check("rr_ack", 32'(ack_a), 32'(1 << exp_idx));
            check("rr_byte", 32'(tx_data_a), 32'(10 * exp_idx));
            check("rr_onehot", 32'($onehot(grant_a)), 32'd1);
            acks++;
            if (k == 15) req_a = '0;
            exp_idx = (exp_idx + 1) % NUM_REQ;
            tick();
            check("rr_ackpulse", 32'(ack_a), 32'd0);
        end
        check("rr_count", bytes_sent_a, 32'(acks));

        // burst of 4 on instance B with requesters 3 and 5
        req_b = 8'b0010_1000;
        for (int k = 0; k < 10; k++) begin
            t0 = 0;
            while (ack_b == '0 && t0 < 60) begin tick(); t0++; end
            check("burst_ack", 32'(ack_b), 32'(1 << burst_order[k]));
            check("burst_byte", 32'(tx_data_b), 32'(burst_order[k] + 1));
            if (k == 9) req_b = '0;
            tick();
        end
        tick();
        check("burst_count", bytes_sent_b, 32'd10);
        check("burst_idle", 32'(active_b), 32'd0);

        // reset during WAIT_LO
        req_a[3] = 1'b1;
        wait_send_a("rst_mid");
        tick(); tick();
        check("rstmid_active", 32'(active_a), 32'd1);
        check("rstmid_busy", 32'(tx_busy_a), 32'd1);
        reset = 1'b1;
        req_a = '0;
        tick();
        check("rstmid_grant", 32'(grant_a), 32'd0);
        check("rstmid_send", 32'(tx_send_a), 32'd0);
        check("rstmid_data", 32'(tx_data_a), 32'd0);
        check("rstmid_bytes", bytes_sent_a, 32'd0);
        check("rstmid_active0", 32'(active_a), 32'd0);
        reset = 1'b0;
        req_a = 8'b0000_0011;
        tick();
        check("rstmid_win0", 32'(grant_a), 32'd1);
        reset = 1'b1;
        req_a = '0;
        tick();
        reset = 1'b0;
        req_a = 8'b0000_0010;
        tick();
        check("rstmid_win1", 32'(grant_a), 32'd2);
        reset = 1'b1;
        req_a = '0;
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ strip readers. Each reader presents one signed convolution result per request.
The block grants requesters round-robin, with an optional burst of consecutive bytes per grant. It saturates the granted word to 8 bits and runs the tx_send/tx_busy handshake.
It returns a one-cycle ack so the granted reader can advance its BRAM address. It sits between the strip BRAM readers and the UART TX core.

Parameters:
NUM_REQ, 8, number of requesters (strip readers)
DATA_W, 23, signed result width per requester
BURST_LEN, 1, max bytes served per grant before rotating (1..255)
BUSY_WAIT, 4, cycles to wait for tx_busy to rise after tx_send before proceeding anyway

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester byte request; level, held until ack
req_data  in  NUM_REQ*DATA_W  packed signed words; slot i = bits [i*DATA_W +: DATA_W]
grant  out  NUM_REQ  one-hot; current owner of the transmitter
ack  out  NUM_REQ  one-hot 1-cycle pulse when the owner's byte has finished transmitting
tx_busy  in  1  UART TX busy
tx_send  out  1  1-cycle pulse to start a UART byte
tx_data  out  8  byte to UART; stable from tx_send until the following ack
active  out  1  high whenever state != IDLE
bytes_sent  out  32  total acked bytes since reset; wraps

Behaviour:
- Reset (sync): state=IDLE. grant, ack, tx_send, tx_data, bytes_sent all 0. active=0. rr_ptr=NUM_REQ-1, so requester 0 wins first. burst_cnt=0.
- IDLE: if req!=0, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Register grant (one-hot) and go to LOAD. Otherwise stay.
- LOAD (1 cycle): capture the granted slot of req_data into data_q. Go to SEND.
- SEND: if tx_busy==0, set tx_data=sat(data_q), pulse tx_send, and go to WAIT_HI. Otherwise hold in SEND (no pulse).
- WAIT_HI: leave for WAIT_LO on tx_busy==1, or after BUSY_WAIT cycles without it.
- WAIT_LO: on tx_busy==0, go to ACK.
- ACK (1 cycle): pulse ack for the granted index, increment bytes_sent and burst_cnt.
  - If req of the owner is still high in the next cycle and burst_cnt<BURST_LEN, go to LOAD with the same grant.
  - Otherwise set rr_ptr=owner, clear grant and burst_cnt, and go to IDLE.
- Latency: req rises in an IDLE cycle, giving grant at N+1, data capture at N+2 and tx_send at N+3 (idle UART). Minimum 6 cycles plus the UART frame per byte.
- Saturation on signed DATA_W: value<0 gives 0x00; value>255 gives 0xFF; otherwise value[7:0].
- Owner deasserts req mid-service: the byte already latched completes and ack still pulses. No new burst byte follows.
- Non-owner req changes never disturb the current transfer.
- Simultaneous requests: round-robin order is guaranteed, with no starvation. Worst-case wait is (NUM_REQ-1)*BURST_LEN bytes.
- Reset mid-transfer: everything returns to reset values next cycle. A byte already handed to the UART is not re-sent.
- Exactly one of grant bits is high outside IDLE, and at most one ack bit per cycle.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, ACK) and the saturation constants SAT_MIN=0 and SAT_MAX=255. These are reused by the strip readers.
- One sub-module: rr_priority_pick. It is combinational: given req and rr_ptr, it returns the one-hot winner and its index.
- Saturation is a small function in the package.

Test Plan:
- Single requester: req[0]=1, data=100, tx_busy modelled as 10 cycles after send → tx_send 3 cycles after req; tx_data=0x64; ack[0] after busy falls; bytes_sent=1.
- Saturation: three bytes on req[2] with data −5, 300, 255 → tx_data 0x00, 0xFF, 0xFF.
- Round robin: req=8'hFF held, BURST_LEN=1, 16 bytes → grant order 0,1,...,7,0,...,7; each ack pulses exactly once per byte.
- Burst: BURST_LEN=4, req[3] and req[5] held → bytes 3,3,3,3,5,5,5,5,3,...
- Busy never rises: tx_busy tied 0 → WAIT_HI times out after 4 cycles; ack still issued; no hang.
- Reset mid-WAIT_LO, then req[1] → all outputs 0 the cycle after reset; next grant goes to requester 0 if req[0] is set, else 1.
